// File: rtl/bpred_pkg.sv
// Shared types and geometry for the fetch-stage branch predictor.
//   ctr_t        2-bit saturating direction counter (SNT/WNT predict not-taken, WT/ST taken)
//   btb_entry_t  one BTB entry {valid, tag, target, ctr}
//   tag_width / num_entries derive the BTB geometry from IDX_BITS
package bpred_pkg;

  function automatic int unsigned tag_width(int unsigned xlen, int unsigned idx_bits);
    // Two low PC bits are dropped: instructions are word aligned.
    return xlen - idx_bits - 2;
  endfunction

  function automatic int unsigned num_entries(int unsigned idx_bits);
    return 2 ** idx_bits;
  endfunction

  localparam int unsigned XLEN        = 32;
  localparam int unsigned IDX_BITS    = 4;
  localparam int unsigned TAG_BITS    = tag_width(XLEN, IDX_BITS);
  localparam int unsigned NUM_ENTRIES = num_entries(IDX_BITS);

  typedef logic [XLEN-1:0]     addr_t;
  typedef logic [IDX_BITS-1:0] idx_t;
  typedef logic [TAG_BITS-1:0] tag_t;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  typedef struct packed {
    logic  valid;
    tag_t  tag;
    addr_t target;
    ctr_t  ctr;
  } btb_entry_t;

  function automatic ctr_t ctr_inc(ctr_t c);
    ctr_t n;
    unique case (c)
      SNT:     n = WNT;
      WNT:     n = WT;
      default: n = ST;
    endcase
    return n;
  endfunction

  function automatic ctr_t ctr_dec(ctr_t c);
    ctr_t n;
    unique case (c)
      ST:      n = WT;
      WT:      n = WNT;
      default: n = SNT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Signal bundle between the pipeline and the branch predictor.
//   master: pipeline side (drives fetch PC, stage controls, E-stage resolution)
//   slave:  predictor side (drives F prediction and E mispredict/redirect)
interface branch_predictor_if;
  import bpred_pkg::*;

  // F stage
  addr_t PCF;
  logic  PredTakenF;
  addr_t PredTargetF;
  // stage controls
  logic  StallD;
  logic  FlushD;
  logic  FlushE;
  // E stage resolution
  addr_t PCE;
  logic  BranchE;
  logic  JumpE;
  logic  RVPCSrcE;
  addr_t PCTargetE;
  logic  MispredictE;
  addr_t RedirectE;

  modport master (
    output PCF, StallD, FlushD, FlushE, PCE, BranchE, JumpE, RVPCSrcE, PCTargetE,
    input  PredTakenF, PredTargetF, MispredictE, RedirectE
  );

  modport slave (
    input  PCF, StallD, FlushD, FlushE, PCE, BranchE, JumpE, RVPCSrcE, PCTargetE,
    output PredTakenF, PredTargetF, MispredictE, RedirectE
  );

endinterface

// File: rtl/bpred_btb.sv
// Direct-mapped branch target buffer storage.
//   clk, reset   clock, synchronous active-high reset (clears valid, counters to WNT)
//   rd_idx_f     F-stage lookup index      -> rd_entry_f (asynchronous)
//   rd_idx_e     E-stage training index    -> rd_entry_e (asynchronous)
//   we/wr_idx/wr_entry  single synchronous write port driven from E
// A same-cycle read and write of one index returns the old contents.
module bpred_btb
  import bpred_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  idx_t       rd_idx_f,
  output btb_entry_t rd_entry_f,
  input  idx_t       rd_idx_e,
  output btb_entry_t rd_entry_e,
  input  logic       we,
  input  idx_t       wr_idx,
  input  btb_entry_t wr_entry
);

  btb_entry_t mem_q [NUM_ENTRIES];

  // Tags and targets are left unreset; an invalid entry never produces a prediction.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        mem_q[i].valid <= 1'b0;
        mem_q[i].ctr   <= WNT;
      end
    end else if (we) begin
      mem_q[wr_idx] <= wr_entry;
    end
  end

  assign rd_entry_f = mem_q[rd_idx_f];
  assign rd_entry_e = mem_q[rd_idx_e];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage dynamic branch predictor: BTB lookup in F, prediction carried F->D->E,
// mispredict detection against the E-stage resolution, and BTB training from E.
//   clk, reset  clock, synchronous active-high reset
//   bp          branch_predictor_if.slave (see interface for signal list)
// Parameter CTR_INIT: counter value given to a newly allocated conditional branch.
module branch_predictor
  import bpred_pkg::*;
#(
  parameter ctr_t CTR_INIT = WT
) (
  input logic               clk,
  input logic               reset,
  branch_predictor_if.slave bp
);

  idx_t       idx_f, idx_e;
  tag_t       tag_f, tag_e;
  btb_entry_t ent_f, ent_e;
  logic       hit_f, hit_e;
  logic       unused_pcf_lsb;

  logic       we;
  btb_entry_t wr_entry;

  logic       d_taken_q, e_taken_q;
  addr_t      d_target_q, e_target_q;

  logic       mispredict;
  addr_t      redirect;
  addr_t      pce_plus4;

  assign idx_f          = bp.PCF[IDX_BITS+1:2];
  assign tag_f          = bp.PCF[XLEN-1:IDX_BITS+2];
  assign idx_e          = bp.PCE[IDX_BITS+1:2];
  assign tag_e          = bp.PCE[XLEN-1:IDX_BITS+2];
  assign unused_pcf_lsb = ^bp.PCF[1:0];

  bpred_btb u_btb (
    .clk        (clk),
    .reset      (reset),
    .rd_idx_f   (idx_f),
    .rd_entry_f (ent_f),
    .rd_idx_e   (idx_e),
    .rd_entry_e (ent_e),
    .we         (we),
    .wr_idx     (idx_e),
    .wr_entry   (wr_entry)
  );

  // F lookup
  assign hit_f          = ent_f.valid && (ent_f.tag == tag_f);
  assign bp.PredTakenF  = hit_f && (ent_f.ctr inside {WT, ST});
  assign bp.PredTargetF = hit_f ? ent_f.target : '0;

  // F->D->E prediction pipeline; FlushD takes priority over StallD.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_taken_q  <= 1'b0;
      d_target_q <= '0;
      e_taken_q  <= 1'b0;
      e_target_q <= '0;
    end else begin
      if (bp.FlushD) begin
        d_taken_q  <= 1'b0;
        d_target_q <= '0;
      end else if (!bp.StallD) begin
        d_taken_q  <= bp.PredTakenF;
        d_target_q <= bp.PredTargetF;
      end
      if (bp.FlushE) begin
        e_taken_q  <= 1'b0;
        e_target_q <= '0;
      end else begin
        e_taken_q  <= d_taken_q;
        e_target_q <= d_target_q;
      end
    end
  end

  // E-stage mispredict check
  assign pce_plus4 = bp.PCE + addr_t'(4);

  always_comb begin
    mispredict = 1'b0;
    redirect   = pce_plus4;
    if (bp.BranchE || bp.JumpE) begin
      mispredict = (e_taken_q != bp.RVPCSrcE) ||
                   (e_taken_q && bp.RVPCSrcE && (e_target_q != bp.PCTargetE));
      if (bp.RVPCSrcE) begin
        redirect = bp.PCTargetE;
      end
    end else if (e_taken_q) begin
      // A non-control instruction aliased onto a taken BTB entry.
      mispredict = 1'b1;
    end
  end

  assign bp.MispredictE = mispredict;
  assign bp.RedirectE   = redirect;

  // BTB training. A flushed E slot reaches here as BranchE=JumpE=0 from the pipeline.
  assign hit_e = ent_e.valid && (ent_e.tag == tag_e);

  always_comb begin
    we       = 1'b0;
    wr_entry = ent_e;
    if (bp.BranchE || bp.JumpE) begin
      if (hit_e) begin
        we = 1'b1;
        if (bp.JumpE) begin
          wr_entry.ctr    = ST;
          wr_entry.target = bp.PCTargetE;
        end else if (bp.RVPCSrcE) begin
          wr_entry.ctr    = ctr_inc(ent_e.ctr);
          wr_entry.target = bp.PCTargetE;
        end else begin
          wr_entry.ctr    = ctr_dec(ent_e.ctr);
        end
      end else if (bp.RVPCSrcE) begin
        we       = 1'b1;
        wr_entry = '{valid: 1'b1, tag: tag_e, target: bp.PCTargetE,
                     ctr: (bp.JumpE ? ST : CTR_INIT)};
      end
    end else if (e_taken_q && hit_e) begin
      we             = 1'b1;
      wr_entry.valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic clk;
  logic reset;

  branch_predictor_if bif ();

  branch_predictor dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: BTB as plain arrays, prediction pipeline as two slots.
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  bit          m_dpt, m_ept;
  logic [31:0] m_dtg, m_etg;

  function automatic int fidx(logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic logic [31:0] ftag(logic [31:0] pc);
    return pc >> 6;
  endfunction

  task automatic chk1(input string tag, input logic obs, input bit exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    int          fi;
    bit          fhit;
    bit          exp_mis;
    logic [31:0] exp_red;
    fi   = fidx(bif.PCF);
    fhit = m_valid[fi] && (m_tag[fi] == ftag(bif.PCF));
    chk1("PredTakenF", bif.PredTakenF, fhit && (m_ctr[fi] >= 2));
    chk32("PredTargetF", bif.PredTargetF, fhit ? m_tgt[fi] : 32'h0);
    exp_red = bif.PCE + 32'd4;
    if (bif.BranchE || bif.JumpE) begin
      exp_mis = (m_ept != bif.RVPCSrcE) ||
                (m_ept && bif.RVPCSrcE && (m_etg != bif.PCTargetE));
      if (bif.RVPCSrcE) exp_red = bif.PCTargetE;
    end else begin
      exp_mis = m_ept;
    end
    chk1("MispredictE", bif.MispredictE, exp_mis);
    if (exp_mis || bif.BranchE || bif.JumpE) chk32("RedirectE", bif.RedirectE, exp_red);
  endtask

  task automatic settle();
    @(negedge clk);
    check_model();
  endtask

  // Advance one clock and apply the same edge to the model (inputs still hold pre-edge values).
  task automatic edge_();
    int          fi, ei;
    bit          fhit, ehit, f_pt;
    logic [31:0] f_tg;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = 1;
      end
      m_dpt = 1'b0; m_dtg = '0; m_ept = 1'b0; m_etg = '0;
    end else begin
      fi   = fidx(bif.PCF);
      fhit = m_valid[fi] && (m_tag[fi] == ftag(bif.PCF));
      f_pt = fhit && (m_ctr[fi] >= 2);
      f_tg = fhit ? m_tgt[fi] : 32'h0;
      ei   = fidx(bif.PCE);
      ehit = m_valid[ei] && (m_tag[ei] == ftag(bif.PCE));
      if (bif.BranchE || bif.JumpE) begin
        if (ehit) begin
          if (bif.JumpE) begin
            m_ctr[ei] = 3; m_tgt[ei] = bif.PCTargetE;
          end else if (bif.RVPCSrcE) begin
            m_ctr[ei] = (m_ctr[ei] < 3) ? m_ctr[ei] + 1 : 3;
            m_tgt[ei] = bif.PCTargetE;
          end else begin
            m_ctr[ei] = (m_ctr[ei] > 0) ? m_ctr[ei] - 1 : 0;
          end
        end else if (bif.RVPCSrcE) begin
          m_valid[ei] = 1'b1;
          m_tag[ei]   = ftag(bif.PCE);
          m_tgt[ei]   = bif.PCTargetE;
          m_ctr[ei]   = bif.JumpE ? 3 : 2;
        end
      end else if (m_ept && ehit) begin
        m_valid[ei] = 1'b0;
      end
      if (bif.FlushE) begin
        m_ept = 1'b0; m_etg = '0;
      end else begin
        m_ept = m_dpt; m_etg = m_dtg;
      end
      if (bif.FlushD) begin
        m_dpt = 1'b0; m_dtg = '0;
      end else if (!bif.StallD) begin
        m_dpt = f_pt; m_dtg = f_tg;
      end
    end
    #1;
  endtask

  task automatic tick();
    settle();
    edge_();
  endtask

  task automatic idle_e();
    bif.PCE       = 32'h1000;
    bif.BranchE   = 1'b0;
    bif.JumpE     = 1'b0;
    bif.RVPCSrcE  = 1'b0;
    bif.PCTargetE = 32'h0;
  endtask

  task automatic set_e(input logic [31:0] pc, input bit br, input bit jmp, input bit taken,
                       input logic [31:0] tgt);
    bif.PCE       = pc;
    bif.BranchE   = br;
    bif.JumpE     = jmp;
    bif.RVPCSrcE  = taken;
    bif.PCTargetE = tgt;
  endtask

  // Fetch pc, let it reach E, resolve it there and check the E outcome.
  task automatic pass(input logic [31:0] pc, input bit br, input bit jmp, input bit taken,
                      input logic [31:0] tgt, input bit exp_mis, input logic [31:0] exp_red,
                      input string tag);
    idle_e();
    bif.PCF = pc;
    tick();
    bif.PCF = 32'h1000;
    tick();
    set_e(pc, br, jmp, taken, tgt);
    settle();
    chk1({tag, "_mis"}, bif.MispredictE, exp_mis);
    chk32({tag, "_redirect"}, bif.RedirectE, exp_red);
    edge_();
    idle_e();
  endtask

  function automatic logic [31:0] rpc();
    return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2);
  endfunction

  initial begin
    int kind;
    reset      = 1'b1;
    bif.PCF    = 32'h100;
    bif.StallD = 1'b0;
    bif.FlushD = 1'b0;
    bif.FlushE = 1'b0;
    idle_e();
    edge_();
    tick();
    reset = 1'b0;

    // 1. Post-reset state
    settle();
    chk1("reset_predtaken", bif.PredTakenF, 1'b0);
    chk1("reset_mispredict", bif.MispredictE, 1'b0);
    edge_();

    // 2. Unpredicted taken branch allocates with CTR_INIT
    pass(32'h100, 1, 0, 1, 32'h80, 1, 32'h80, "t2");
    bif.PCF = 32'h100;
    settle();
    chk1("t2_predtaken", bif.PredTakenF, 1'b1);
    chk32("t2_predtarget", bif.PredTargetF, 32'h80);
    edge_();

    // 3. Two not-taken resolutions: 10 -> 01 -> 00
    pass(32'h100, 1, 0, 0, 32'h80, 1, 32'h104, "t3a");
    pass(32'h100, 1, 0, 0, 32'h80, 0, 32'h104, "t3b");
    bif.PCF = 32'h100;
    settle();
    chk1("t3_predtaken", bif.PredTakenF, 1'b0);
    edge_();

    // 4. Saturate at 11, one not-taken leaves it predicting taken
    pass(32'h100, 1, 0, 1, 32'h80, 1, 32'h80, "t4a");
    pass(32'h100, 1, 0, 1, 32'h80, 1, 32'h80, "t4b");
    pass(32'h100, 1, 0, 1, 32'h80, 0, 32'h80, "t4c");
    pass(32'h100, 1, 0, 1, 32'h80, 0, 32'h80, "t4d");
    pass(32'h100, 1, 0, 0, 32'h80, 1, 32'h104, "t4e");
    bif.PCF = 32'h100;
    settle();
    chk1("t4_predtaken", bif.PredTakenF, 1'b1);
    edge_();

    // 5. Jump allocation, correct prediction, then a target change
    pass(32'h200, 0, 1, 1, 32'h300, 1, 32'h300, "t5a");
    pass(32'h200, 0, 1, 1, 32'h300, 0, 32'h300, "t5b");
    pass(32'h200, 0, 1, 1, 32'h340, 1, 32'h340, "t5c");
    bif.PCF = 32'h200;
    settle();
    chk32("t5_newtarget", bif.PredTargetF, 32'h340);
    edge_();

    // 6a. StallD holds the D prediction
    bif.PCF = 32'h200; tick();
    bif.StallD = 1'b1; bif.PCF = 32'h1000; tick();
    bif.StallD = 1'b0; tick();
    set_e(32'h200, 0, 1, 1, 32'h340);
    settle();
    chk1("stall_mis", bif.MispredictE, 1'b0);
    edge_();
    idle_e();

    // 6b. FlushE clears the E prediction
    bif.PCF = 32'h200; tick();
    bif.PCF = 32'h1000; bif.FlushE = 1'b1; tick();
    bif.FlushE = 1'b0;
    set_e(32'h200, 0, 1, 1, 32'h340);
    settle();
    chk1("flushe_mis", bif.MispredictE, 1'b1);
    edge_();
    idle_e();

    // 6c. FlushD wins over StallD
    bif.PCF = 32'h200; bif.FlushD = 1'b1; bif.StallD = 1'b1; tick();
    bif.FlushD = 1'b0; bif.StallD = 1'b0; bif.PCF = 32'h1000; tick();
    set_e(32'h200, 0, 1, 1, 32'h340);
    settle();
    chk1("flushd_mis", bif.MispredictE, 1'b1);
    edge_();
    idle_e();

    // 6d. Aliasing non-branch invalidates the entry
    pass(32'h200, 0, 0, 0, 32'h0, 1, 32'h204, "alias");
    bif.PCF = 32'h200;
    settle();
    chk1("alias_invalid", bif.PredTakenF, 1'b0);
    edge_();

    // 6e. Reset mid-stream drops entries and in-flight predictions
    pass(32'h200, 0, 1, 1, 32'h300, 1, 32'h300, "realloc");
    bif.PCF = 32'h200; tick();
    reset = 1'b1; tick();
    reset = 1'b0;
    set_e(32'h200, 0, 1, 1, 32'h300);
    settle();
    chk1("midreset_predtaken", bif.PredTakenF, 1'b0);
    chk1("midreset_mis", bif.MispredictE, 1'b1);
    edge_();
    idle_e();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      reset      = ($urandom_range(0, 63) == 0);
      bif.PCF    = rpc();
      bif.StallD = ($urandom_range(0, 7) == 0);
      bif.FlushD = ($urandom_range(0, 7) == 0);
      bif.FlushE = ($urandom_range(0, 7) == 0);
      kind       = int'($urandom_range(0, 3));
      set_e(rpc(), kind == 2, kind == 3,
            (kind == 3) || ((kind == 2) && ($urandom_range(0, 1) == 1)),
            32'h400 | (32'($urandom_range(0, 3)) << 4));
      tick();
    end
    reset = 1'b0;
    bif.StallD = 1'b0; bif.FlushD = 1'b0; bif.FlushE = 1'b0;
    idle_e();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
